// File: rtl/cp0_int_unit.sv
// Coprocessor-0 and interrupt unit.
// Holds Status (IE, IM), Cause (ExcCode, IP) and EPC. Synchronises and
// edge-detects external interrupt lines into pending bits. Raises INTsignal
// to the control FSM and supplies redirect PCs and mfc0 read data.
module cp0_int_unit #(
    parameter int          NUM_IRQ           = 4,
    parameter logic [31:0] HANDLER_ADDR      = 32'h0000_0008,
    parameter int          INT_SIGNALS_WIDTH = 7
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [INT_SIGNALS_WIDTH-1:0] int_signals,
    input  logic [31:0]                  INTcause,
    input  logic [31:0]                  epc_in,
    input  logic [4:0]                   cp0_addr,
    input  logic [31:0]                  cp0_wdata,
    input  logic [NUM_IRQ-1:0]           irq_in,
    output logic                         INTsignal,
    output logic [31:0]                  cp0_rdata,
    output logic [31:0]                  int_pc,
    output logic                         int_pc_sel,
    output logic [31:0]                  epc_out,
    output logic                         status_ie
);

    localparam logic [4:0]  ADDR_STATUS = 5'd12;
    localparam logic [4:0]  ADDR_CAUSE  = 5'd13;
    localparam logic [4:0]  ADDR_EPC    = 5'd14;
    localparam logic [31:0] CAUSE_INT   = 32'd1;

    // Field split of the FSM control bundle.
    logic [1:0] w_pcint;
    logic       w_epc_write;
    logic       w_int_enable;
    logic       w_int_disable;
    logic       w_cp0_reg_write;
    logic       w_reg_write_source;

    assign w_pcint            = int_signals[6:5];
    assign w_epc_write        = int_signals[4];
    assign w_int_enable       = int_signals[3];
    assign w_int_disable      = int_signals[2];
    assign w_cp0_reg_write    = int_signals[1];
    assign w_reg_write_source = int_signals[0];

    // RegWriteSource only steers the register-file write mux downstream;
    // read data here is always valid, so the bit is not consumed.
    logic w_unused_rws;
    assign w_unused_rws = w_reg_write_source;

    // Architectural state.
    logic               r_ie;
    logic [NUM_IRQ-1:0] r_im;
    logic [4:0]         r_exc_code;
    logic [31:0]        r_epc;
    logic [NUM_IRQ-1:0] r_pending;

    // IRQ synchroniser and edge-detect flops.
    logic [NUM_IRQ-1:0] r_sync1;
    logic [NUM_IRQ-1:0] r_sync2;
    logic [NUM_IRQ-1:0] r_sync3;

    logic [NUM_IRQ-1:0] w_irq_edge;
    logic [NUM_IRQ-1:0] w_masked_pending;
    logic [NUM_IRQ-1:0] w_ack_mask;
    logic               w_ack_req;
    logic               w_mtc0_status;
    logic               w_mtc0_cause;
    logic               w_mtc0_epc;
    logic [31:0]        w_status_rd;
    logic [31:0]        w_cause_rd;

    // Isolate the lowest-index set bit (highest-priority line).
    function automatic logic [NUM_IRQ-1:0] lowest_set(input logic [NUM_IRQ-1:0] v);
        logic [NUM_IRQ-1:0] res;
        logic               found;
        res   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (v[i] && !found) begin
                res[i] = 1'b1;
                found  = 1'b1;
            end else begin
                res[i] = 1'b0;
            end
        end
        return res;
    endfunction

    assign w_irq_edge       = r_sync2 & ~r_sync3;
    assign w_masked_pending = r_pending & r_im;
    assign w_ack_req        = w_epc_write && (INTcause == CAUSE_INT);
    assign w_ack_mask       = w_ack_req ? lowest_set(w_masked_pending) : {NUM_IRQ{1'b0}};

    assign w_mtc0_status = w_cp0_reg_write && (cp0_addr == ADDR_STATUS);
    assign w_mtc0_cause  = w_cp0_reg_write && (cp0_addr == ADDR_CAUSE);
    assign w_mtc0_epc    = w_cp0_reg_write && (cp0_addr == ADDR_EPC);

    // Two-flop synchroniser plus one delay flop for rising-edge detection.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_sync3 <= '0;
        end else begin
            r_sync1 <= irq_in;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    // Pending bits: acknowledge clears the serviced line, a new edge re-sets
    // it (set wins over a same-cycle clear).
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_ack_mask) | w_irq_edge;
        end
    end

    // Status.IE: disable beats enable, both beat a software write.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ie <= 1'b0;
        end else if (w_int_disable) begin
            r_ie <= 1'b0;
        end else if (w_int_enable) begin
            r_ie <= 1'b1;
        end else if (w_mtc0_status) begin
            r_ie <= cp0_wdata[0];
        end else begin
            r_ie <= r_ie;
        end
    end

    // Status.IM: software-written only.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_im <= '0;
        end else if (w_mtc0_status) begin
            r_im <= cp0_wdata[8 +: NUM_IRQ];
        end else begin
            r_im <= r_im;
        end
    end

    // Cause.ExcCode: hardware exception entry beats a software write.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_exc_code <= 5'd0;
        end else if (w_epc_write) begin
            r_exc_code <= INTcause[4:0];
        end else if (w_mtc0_cause) begin
            r_exc_code <= cp0_wdata[6:2];
        end else begin
            r_exc_code <= r_exc_code;
        end
    end

    // EPC: hardware exception entry beats a software write.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_epc <= 32'd0;
        end else if (w_epc_write) begin
            r_epc <= epc_in;
        end else if (w_mtc0_epc) begin
            r_epc <= cp0_wdata;
        end else begin
            r_epc <= r_epc;
        end
    end

    // Readable images of Status and Cause with unimplemented bits at zero.
    always_comb begin
        w_status_rd                  = 32'd0;
        w_status_rd[0]               = r_ie;
        w_status_rd[8 +: NUM_IRQ]    = r_im;
        w_cause_rd                   = 32'd0;
        w_cause_rd[6:2]              = r_exc_code;
        w_cause_rd[8 +: NUM_IRQ]     = r_pending;
    end

    // mfc0 read decode.
    always_comb begin
        cp0_rdata = 32'd0;
        case (cp0_addr)
            ADDR_STATUS: cp0_rdata = w_status_rd;
            ADDR_CAUSE:  cp0_rdata = w_cause_rd;
            ADDR_EPC:    cp0_rdata = r_epc;
            default:     cp0_rdata = 32'd0;
        endcase
    end

    // PC redirect select: handler entry or eret return.
    always_comb begin
        int_pc     = 32'd0;
        int_pc_sel = 1'b0;
        case (w_pcint)
            2'b01: begin
                int_pc     = HANDLER_ADDR;
                int_pc_sel = 1'b1;
            end
            2'b10: begin
                int_pc     = r_epc;
                int_pc_sel = 1'b1;
            end
            default: begin
                int_pc     = 32'd0;
                int_pc_sel = 1'b0;
            end
        endcase
    end

    // Interrupt request depends on registers only, so it never glitches
    // within a cycle.
    assign INTsignal = r_ie & (|w_masked_pending);
    assign epc_out   = r_epc;
    assign status_ie = r_ie;

endmodule

// File: tb/tb_cp0_int_unit.sv
// Scoreboard bench for cp0_int_unit: stimulus pushes expected outputs from a
// behavioural CP0 model, a monitor pops and compares on the falling edge.
module tb_cp0_int_unit;

    localparam int N = 4;

    logic        clk;
    logic        reset;
    logic [6:0]  int_signals;
    logic [31:0] INTcause;
    logic [31:0] epc_in;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [N-1:0] irq_in;
    logic        INTsignal;
    logic [31:0] cp0_rdata;
    logic [31:0] int_pc;
    logic        int_pc_sel;
    logic [31:0] epc_out;
    logic        status_ie;

    cp0_int_unit #(
        .NUM_IRQ(N),
        .HANDLER_ADDR(32'h0000_0008),
        .INT_SIGNALS_WIDTH(7)
    ) dut (
        .clk(clk),
        .reset(reset),
        .int_signals(int_signals),
        .INTcause(INTcause),
        .epc_in(epc_in),
        .cp0_addr(cp0_addr),
        .cp0_wdata(cp0_wdata),
        .irq_in(irq_in),
        .INTsignal(INTsignal),
        .cp0_rdata(cp0_rdata),
        .int_pc(int_pc),
        .int_pc_sel(int_pc_sel),
        .epc_out(epc_out),
        .status_ie(status_ie)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        intsig;
        logic [31:0] rdata;
        logic [31:0] ipc;
        logic        sel;
        logic [31:0] epc;
        logic        ie;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Behavioural model state.
    bit          m_ie;
    bit [N-1:0]  m_im;
    bit [4:0]    m_exc;
    bit [31:0]   m_epc;
    bit          m_pend[N];
    logic [N-1:0] samples[$];   // irq_in values seen at recent clock edges

    function automatic bit any_enabled_pending();
        for (int i = 0; i < N; i++)
            if (m_pend[i] && m_im[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        logic [31:0] v;
        v = 32'd0;
        if (a == 5'd12) begin
            v = {20'd0, m_im, 7'd0, m_ie};
        end else if (a == 5'd13) begin
            for (int i = 0; i < N; i++) v[8 + i] = m_pend[i];
            v[6:2] = m_exc;
        end else if (a == 5'd14) begin
            v = m_epc;
        end
        return v;
    endfunction

    // Apply one clock edge's worth of architectural rules to the model.
    task automatic model_edge(input logic rst, input logic ew, en, dis, rw,
                              input logic [31:0] cause, ein,
                              input logic [4:0] addr, input logic [31:0] wd,
                              input logic [N-1:0] irq);
        logic [N-1:0] rising;
        if (!rst) begin
            m_ie = 1'b0; m_im = '0; m_exc = '0; m_epc = '0;
            for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
            samples.delete();
            for (int k = 0; k < 3; k++) samples.push_back('0);
        end else begin
            // A rise between two consecutive samples becomes pending two
            // edges after the later of them.
            rising = samples[1] & ~samples[0];
            if (ew && cause == 32'd1) begin
                for (int i = 0; i < N; i++) begin
                    if (m_pend[i] && m_im[i]) begin
                        m_pend[i] = 1'b0;
                        break;
                    end
                end
            end
            for (int i = 0; i < N; i++) if (rising[i]) m_pend[i] = 1'b1;
            samples.push_back(irq);
            samples.pop_front();
            if (dis)                          m_ie = 1'b0;
            else if (en)                      m_ie = 1'b1;
            else if (rw && addr == 5'd12)     m_ie = wd[0];
            if (rw && addr == 5'd12)          m_im = wd[8 +: N];
            if (ew)                           m_exc = cause[4:0];
            else if (rw && addr == 5'd13)     m_exc = wd[6:2];
            if (ew)                           m_epc = ein;
            else if (rw && addr == 5'd14)     m_epc = wd;
        end
    endtask

    // Drive one cycle of inputs, queue the expected response, step the model.
    task automatic drive(input bit chk, input logic rst, input logic [1:0] pc,
                         input logic ew, en, dis, rw,
                         input logic [31:0] cause, ein,
                         input logic [4:0] addr, input logic [31:0] wd,
                         input logic [N-1:0] irq);
        exp_t e;
        reset       = rst;
        int_signals = {pc, ew, en, dis, rw, rw};
        INTcause    = cause;
        epc_in      = ein;
        cp0_addr    = addr;
        cp0_wdata   = wd;
        irq_in      = irq;
        if (chk) begin
            e.intsig = m_ie && any_enabled_pending();
            e.rdata  = model_read(addr);
            e.ipc    = (pc == 2'b01) ? 32'h0000_0008 : (pc == 2'b10) ? m_epc : 32'd0;
            e.sel    = (pc == 2'b01) || (pc == 2'b10);
            e.epc    = m_epc;
            e.ie     = m_ie;
            exp_q.push_back(e);
        end
        @(posedge clk);
        model_edge(rst, ew, en, dis, rw, cause, ein, addr, wd, irq);
        #1;
    endtask

    task automatic idle(input logic [4:0] addr, input logic [N-1:0] irq);
        drive(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, addr, 32'd0, irq);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compare every queued expectation against the live outputs.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("INTsignal",  {31'd0, INTsignal},  {31'd0, e.intsig});
            check("cp0_rdata",  cp0_rdata,           e.rdata);
            check("int_pc",     int_pc,              e.ipc);
            check("int_pc_sel", {31'd0, int_pc_sel}, {31'd0, e.sel});
            check("epc_out",    epc_out,             e.epc);
            check("status_ie",  {31'd0, status_ie},  {31'd0, e.ie});
        end
    end

    initial begin
        logic [N-1:0] irq_r;
        logic [4:0]   a_r;
        logic [31:0]  c_r;
        // Reset held two cycles with all lines high.
        drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd13, 32'd0, 4'hF);
        drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd13, 32'd0, 4'hF);
        for (int i = 0; i < 5; i++) idle(5'd13, 4'hF);
        // Mid-operation reset discards the pending lines collected above.
        drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd13, 32'd0, 4'h0);
        idle(5'd13, 4'h0);
        // Enable IE and all masks, then pulse line 2.
        drive(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 5'd12, 32'h0000_0F01, 4'h0);
        idle(5'd12, 4'b0100);
        for (int i = 0; i < 4; i++) idle(5'd13, 4'b0000);
        // Interrupt entry with acknowledge.
        drive(1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 32'd1, 32'h0000_0040, 5'd13, 32'd0, 4'h0);
        idle(5'd13, 4'h0);
        // Lines 1 and 3 together, single acknowledge keeps line 3 pending.
        idle(5'd13, 4'b1010);
        for (int i = 0; i < 3; i++) idle(5'd13, 4'b0000);
        drive(1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 32'd1, 32'h0000_0040, 5'd13, 32'd0, 4'h0);
        idle(5'd13, 4'h0);
        // eret restores IE; line 3 fires again.
        drive(1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 5'd14, 32'd0, 4'h0);
        idle(5'd13, 4'h0);
        // Same-cycle EPC conflict and enable/disable conflict.
        drive(1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 32'd8, 32'h0000_0080, 5'd14, 32'h0000_1234, 4'h0);
        drive(1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 5'd14, 32'd0, 4'h0);
        idle(5'd12, 4'h0);
        // Same-cycle acknowledge and new edge on the same line: set wins.
        drive(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 5'd12, 32'h0000_0101, 4'h1);
        idle(5'd13, 4'h0);
        idle(5'd13, 4'h0);
        idle(5'd13, 4'h0);
        idle(5'd13, 4'h1);
        idle(5'd13, 4'h0);
        drive(1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 32'd1, 32'h0000_0044, 5'd13, 32'd0, 4'h0);
        idle(5'd13, 4'h0);

        // Randomised traffic.
        irq_r = '0;
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 3) == 0) irq_r = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0:       a_r = 5'd12;
                1:       a_r = 5'd13;
                2:       a_r = 5'd14;
                default: a_r = 5'($urandom_range(0, 31));
            endcase
            case ($urandom_range(0, 3))
                0, 1:    c_r = 32'd1;
                2:       c_r = 32'd8;
                default: c_r = $urandom;
            endcase
            drive(1'b1, ($urandom_range(0, 99) != 0), 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
                  c_r, $urandom, a_r, $urandom, irq_r);
        end
        idle(5'd0, 4'h0);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
